// File: rtl/care_action_ctrl.sv
// Care-action menu controller: debounced NEXT/SELECT buttons drive a six-entry
// cursor and fire one-cycle action pulses separated by a global cooldown.

module care_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    logic             sync_p0;
    logic             sync_p1;
    logic             level_p2;
    logic             level_p3;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            level_p2 <= 1'b0;
            level_p3 <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            // synchronizer stage
            sync_p0 <= raw;
            sync_p1 <= sync_p0;

            // debounce stage: level only moves after DEBOUNCE_CYCLES of disagreement
            if (sync_p1 == level_p2) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_p2 <= sync_p1;
                cnt      <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // edge stage: press on debounced rise only
            level_p3 <= level_p2;
            press    <= level_p2 & ~level_p3;
        end
    end

endmodule

module care_action_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COOLDOWN_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_select,
    output logic [7:0] actions,
    output logic [2:0] menu_sel,
    output logic [2:0] last_action,
    output logic       cooldown_active,
    output logic       reject
);

    localparam int MAX_CYC = (DEBOUNCE_CYCLES > COOLDOWN_CYCLES) ? DEBOUNCE_CYCLES
                                                                 : COOLDOWN_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FIRE     = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    logic             next_press;
    logic             sel_press;
    logic [1:0]       state;
    logic [2:0]       idx;
    logic [CNT_W-1:0] cd_cnt;

    function automatic logic [7:0] action_vec(input logic [2:0] i);
        action_vec = 8'd0;
        if (i <= 3'd5) begin
            action_vec[i] = 1'b1;
        end
    endfunction

    function automatic logic [2:0] next_sel(input logic [2:0] s);
        next_sel = (s >= 3'd5) ? 3'd0 : s + 3'd1;
    endfunction

    care_btn_cond #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_next (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_next),
        .press(next_press)
    );

    care_btn_cond #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_select (
        .clk  (clk),
        .reset(reset),
        .raw  (btn_select),
        .press(sel_press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= 3'd0;
            cd_cnt      <= '0;
            menu_sel    <= 3'd0;
            last_action <= 3'd0;
            actions     <= 8'd0;
            reject      <= 1'b0;
        end else begin
            actions <= 8'd0;
            reject  <= 1'b0;

            if (next_press) begin
                menu_sel <= next_sel(menu_sel);
            end

            // actions is registered on IDLE->FIRE so it is high exactly during FIRE
            case (state)
                ST_IDLE: begin
                    if (sel_press) begin
                        idx     <= menu_sel;
                        actions <= action_vec(menu_sel);
                        state   <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    last_action <= idx;
                    cd_cnt      <= CNT_W'(COOLDOWN_CYCLES - 1);
                    reject      <= sel_press;
                    state       <= ST_COOLDOWN;
                end
                ST_COOLDOWN: begin
                    reject <= sel_press;
                    if (cd_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cd_cnt <= cd_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cooldown_active = (state == ST_COOLDOWN);

endmodule

// File: tb/tb_care_action_ctrl.sv
// Scoreboard bench for care_action_ctrl with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8.

module tb_care_action_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_select = 1'b0;
    logic [7:0] actions;
    logic [2:0] menu_sel;
    logic [2:0] last_action;
    logic       cooldown_active;
    logic       reject;

    care_action_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .COOLDOWN_CYCLES(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_next       (btn_next),
        .btn_select     (btn_select),
        .actions        (actions),
        .menu_sel       (menu_sel),
        .last_action    (last_action),
        .cooldown_active(cooldown_active),
        .reject         (reject)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_rej;
        logic [7:0] act;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   last_act_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic is_rej, input logic [7:0] a, input int c);
        exp_t e;
        e.is_rej = is_rej;
        e.act    = a;
        e.cyc    = c;
        q.push_back(e);
    endtask

    // monitor: every action or reject pulse must match the head of the queue
    always @(negedge clk) begin
        if (!reset && (actions != 8'd0 || reject)) begin
            if (q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_output: actions=%h reject=%b cycle %0d, nothing expected",
                         actions, reject, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_actions", {24'd0, actions}, {24'd0, e.act});
                chk("pulse_reject", {31'd0, reject}, {31'd0, e.is_rej});
                chk("pulse_cycle", cyc, e.cyc);
                if (actions != 8'd0) begin
                    if (last_act_cyc >= 0)
                        chk("pulse_spacing_ge_10", {31'd0, (cyc - last_act_cyc) >= 10}, 32'd1);
                    last_act_cyc = cyc;
                end
            end
        end
    end

    task automatic press_next(input logic [2:0] exp_sel);
        @(negedge clk);
        btn_next = 1'b1;
        repeat (6) @(negedge clk);
        btn_next = 1'b0;
        repeat (12) @(negedge clk);
        chk("menu_sel_after_next", {29'd0, menu_sel}, {29'd0, exp_sel});
    endtask

    // raise SELECT for 6 samples; returns at the negedge where k+6 is current
    task automatic fire_select(input logic [7:0] a, output int k);
        @(negedge clk);
        k = cyc;
        push(1'b0, a, k + 8);
        btn_select = 1'b1;
        repeat (6) @(negedge clk);
        btn_select = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int k;
        int hi_cnt;
        int first_hi;

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {16'd0, actions, menu_sel, last_action, cooldown_active, reject}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_menu_sel", {29'd0, menu_sel}, 32'd0);
        chk("post_reset_cooldown", {31'd0, cooldown_active}, 32'd0);

        // six NEXT presses wrap 1..5,0 with no action pulses
        press_next(3'd1);
        press_next(3'd2);
        press_next(3'd3);
        press_next(3'd4);
        press_next(3'd5);
        press_next(3'd0);

        // three NEXT then SELECT fires action 3 and cooldown lasts 8 cycles
        press_next(3'd1);
        press_next(3'd2);
        press_next(3'd3);
        fire_select(8'h08, k);
        hi_cnt   = 0;
        first_hi = -1;
        repeat (14) begin
            @(negedge clk);
            if (cooldown_active) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = cyc;
            end
        end
        chk("cooldown_len", hi_cnt, 8);
        chk("cooldown_start", first_hi, k + 9);
        chk("last_action_3", {29'd0, last_action}, 32'd3);
        repeat (10) @(negedge clk);

        // SELECT glitches of 1..3 samples are ignored; a 4-sample hold fires
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            btn_select = 1'b1;
            repeat (n) @(negedge clk);
            btn_select = 1'b0;
            repeat (8) @(negedge clk);
        end
        @(negedge clk);
        k = cyc;
        push(1'b0, 8'h08, k + 8);
        btn_select = 1'b1;
        repeat (4) @(negedge clk);
        btn_select = 1'b0;
        repeat (25) @(negedge clk);

        // second press lands in COOLDOWN and is rejected, not queued
        @(negedge clk);
        k = cyc;
        push(1'b0, 8'h08, k + 8);
        push(1'b1, 8'h00, k + 16);
        btn_select = 1'b1;
        repeat (4) @(negedge clk);
        btn_select = 1'b0;
        repeat (4) @(negedge clk);
        btn_select = 1'b1;
        repeat (4) @(negedge clk);
        btn_select = 1'b0;
        repeat (20) @(negedge clk);
        chk("cooldown_done_after_reject", {31'd0, cooldown_active}, 32'd0);

        // SELECT after cooldown fires normally
        fire_select(8'h08, k);
        repeat (25) @(negedge clk);

        // move cursor to 2, then NEXT and SELECT together
        press_next(3'd4);
        press_next(3'd5);
        press_next(3'd0);
        press_next(3'd1);
        press_next(3'd2);
        @(negedge clk);
        k = cyc;
        push(1'b0, 8'h04, k + 8);
        btn_next   = 1'b1;
        btn_select = 1'b1;
        repeat (7) @(negedge clk);
        chk("menu_sel_before_adv", {29'd0, menu_sel}, 32'd2);
        @(negedge clk);
        chk("menu_sel_after_adv", {29'd0, menu_sel}, 32'd3);
        btn_next   = 1'b0;
        btn_select = 1'b0;
        repeat (25) @(negedge clk);
        chk("last_action_2", {29'd0, last_action}, 32'd2);

        // asynchronous reset three cycles into COOLDOWN
        fire_select(8'h08, k);
        repeat (5) @(negedge clk);
        chk("cooldown_before_reset", {31'd0, cooldown_active}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", {16'd0, actions, menu_sel, last_action, cooldown_active, reject}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("menu_sel_after_reset", {29'd0, menu_sel}, 32'd0);
        chk("cooldown_after_reset", {31'd0, cooldown_active}, 32'd0);

        // back in IDLE: cursor 0 fires action 0
        fire_select(8'h01, k);
        repeat (25) @(negedge clk);

        chk("scoreboard_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
